// File: rtl/tri_vertex_unpacker.sv
// Triangle-to-vertex unpacker: buffers 9-coordinate triangle words from the
// serial collector and streams them out as three x/y/z vertices over a
// valid/ready handshake. Triangles that arrive with no free slot are dropped
// and flagged with a sticky overflow bit.
module tri_vertex_unpacker #(
    parameter int unsigned COORD_W = 16,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9*COORD_W-1:0] tri_in,
    input  logic                 tri_done,
    output logic                 vtx_valid,
    input  logic                 vtx_ready,
    output logic [COORD_W-1:0]   vtx_x,
    output logic [COORD_W-1:0]   vtx_y,
    output logic [COORD_W-1:0]   vtx_z,
    output logic [1:0]           vtx_idx,
    output logic                 vtx_last,
    output logic                 fifo_full,
    output logic                 overflow,
    output logic [7:0]           tri_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned VW = 3 * COORD_W;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0] ONE_CNT  = (PW + 1)'(1);
    localparam logic [PW-1:0] ONE_PTR = PW'(1);

    typedef enum logic [0:0] {StEmpty, StStream} state_e;

    state_e               state_q, state_d;
    logic [9*COORD_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PW:0]          count_q, count_d;
    logic [1:0]           idx_q, idx_d;
    logic                 overflow_q;
    logic [7:0]           tri_count_q;

    logic                 fire, pop, slot_avail, wr_en;
    logic [9*COORD_W-1:0] head_word;
    logic [VW-1:0]        head_vtx;

    // Handshake and write-acceptance decode; a full FIFO still accepts when
    // its head triangle retires in the same cycle.
    always_comb begin
        fire       = (state_q == StStream) && vtx_ready;
        pop        = fire && (idx_q == 2'd2);
        slot_avail = (count_q < FULL_CNT) || pop;
        wr_en      = tri_done && slot_avail;
    end

    // Next-state logic: occupancy, vertex index and stream/empty state.
    always_comb begin
        count_d = count_q;
        idx_d   = idx_q;
        state_d = StEmpty;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
        if (fire) begin
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
        if (count_d != '0) begin
            state_d = StStream;
        end
    end

    // Output mux: select the current vertex of the head triangle.
    always_comb begin
        head_word = mem_q[rd_ptr_q];
        case (idx_q)
            2'd0:    head_vtx = head_word[VW-1:0];
            2'd1:    head_vtx = head_word[2*VW-1:VW];
            default: head_vtx = head_word[3*VW-1:2*VW];
        endcase
        vtx_x     = head_vtx[COORD_W-1:0];
        vtx_y     = head_vtx[2*COORD_W-1:COORD_W];
        vtx_z     = head_vtx[3*COORD_W-1:2*COORD_W];
        vtx_valid = (state_q == StStream);
        vtx_idx   = idx_q;
        vtx_last  = (idx_q == 2'd2);
        fifo_full = (count_q == FULL_CNT);
        overflow  = overflow_q;
        tri_count = tri_count_q;
    end

    // Control state; reset discards any partially streamed triangle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            count_q     <= '0;
            idx_q       <= 2'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            tri_count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ONE_PTR;
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + ONE_PTR;
                tri_count_q <= tri_count_q + 8'd1;
            end
            if (tri_done && !slot_avail) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Triangle storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= tri_in;
        end
    end

endmodule

// File: tb/tb_tri_vertex_unpacker.sv
// Self-checking bench for tri_vertex_unpacker: directed scenarios followed by
// random traffic, all checked against a queue-based triangle model.
module tb_tri_vertex_unpacker;

    localparam int unsigned COORD_W = 16;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned TW      = 9 * COORD_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [TW-1:0]      tri_in = '0;
    logic               tri_done = 1'b0;
    logic               vtx_valid;
    logic               vtx_ready = 1'b0;
    logic [COORD_W-1:0] vtx_x, vtx_y, vtx_z;
    logic [1:0]         vtx_idx;
    logic               vtx_last, fifo_full, overflow;
    logic [7:0]         tri_count;

    tri_vertex_unpacker #(.COORD_W(COORD_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .tri_in    (tri_in),
        .tri_done  (tri_done),
        .vtx_valid (vtx_valid),
        .vtx_ready (vtx_ready),
        .vtx_x     (vtx_x),
        .vtx_y     (vtx_y),
        .vtx_z     (vtx_z),
        .vtx_idx   (vtx_idx),
        .vtx_last  (vtx_last),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .tri_count (tri_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queued triangle words, current vertex, counters.
    logic [TW-1:0] mq [$];
    int            m_idx = 0;
    int            m_cnt = 0;
    bit            m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [TW-1:0] mk_tri(input int base);
        logic [TW-1:0] w = '0;
        for (int v = 0; v < 3; v++) begin
            for (int c = 0; c < 3; c++) begin
                w[(3 * v + c) * COORD_W +: COORD_W] = COORD_W'(base + 16 * v + c + 1);
            end
        end
        return w;
    endfunction

    function automatic logic [TW-1:0] rand_word();
        logic [159:0] r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[TW-1:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_idx = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic check_all();
        logic [TW-1:0] w;
        chk("valid", 32'(vtx_valid), 32'(mq.size() > 0));
        chk("idx", 32'(vtx_idx), m_idx);
        chk("last", 32'(vtx_last), 32'(m_idx == 2));
        chk("full", 32'(fifo_full), 32'(mq.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("tri_count", 32'(tri_count), m_cnt);
        if (mq.size() > 0) begin
            w = mq[0] >> (3 * COORD_W * m_idx);
            chk("vtx_x", 32'(vtx_x), 32'(w[COORD_W-1:0]));
            chk("vtx_y", 32'(vtx_y), 32'(w[2*COORD_W-1:COORD_W]));
            chk("vtx_z", 32'(vtx_z), 32'(w[3*COORD_W-1:2*COORD_W]));
        end
    endtask

    task automatic model_edge(input logic done, input logic [TW-1:0] word, input logic ready);
        bit fire = (mq.size() > 0) && ready;
        bit pop  = fire && (m_idx == 2);
        bit acc  = 1'b0;
        if (done) begin
            if (mq.size() < DEPTH || pop) acc = 1'b1;
            else m_ovf = 1'b1;
        end
        if (fire) begin
            if (m_idx == 2) begin
                m_idx = 0;
                void'(mq.pop_front());
                m_cnt = (m_cnt + 1) % 256;
            end else begin
                m_idx++;
            end
        end
        if (acc) mq.push_back(word);
    endtask

    // One clock: drive inputs, check pre-edge outputs, advance model and DUT.
    task automatic cycle(input logic done, input logic [TW-1:0] word, input logic ready);
        tri_done  = done;
        tri_in    = word;
        vtx_ready = ready;
        #1;
        check_all();
        model_edge(done, word, ready);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        tri_done  = 1'b0;
        vtx_ready = 1'b0;
        rst       = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 32'(vtx_valid), 0);
        chk("rst_idx", 32'(vtx_idx), 0);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_count", 32'(tri_count), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [TW-1:0] t1;
        t1 = mk_tri(0);

        // Power-on reset.
        #1;
        do_reset();

        // Single triangle with literal expectations.
        cycle(1'b1, t1, 1'b1);
        chk("t1_b0_x", 32'(vtx_x), 32'h0001);
        chk("t1_b0_z", 32'(vtx_z), 32'h0003);
        chk("t1_b0_last", 32'(vtx_last), 0);
        cycle(1'b0, '0, 1'b1);
        chk("t1_b1_y", 32'(vtx_y), 32'h0012);
        chk("t1_b1_idx", 32'(vtx_idx), 1);
        cycle(1'b0, '0, 1'b1);
        chk("t1_b2_x", 32'(vtx_x), 32'h0021);
        chk("t1_b2_z", 32'(vtx_z), 32'h0023);
        chk("t1_b2_last", 32'(vtx_last), 1);
        cycle(1'b0, '0, 1'b1);
        chk("t1_done_valid", 32'(vtx_valid), 0);
        chk("t1_done_count", 32'(tri_count), 1);

        // Backpressure at idx 1.
        cycle(1'b1, mk_tri(32'h100), 1'b1);
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0);
        chk("bp_hold_x", 32'(vtx_x), 32'h0111);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

        // Write coinciding with the final pop of a full FIFO.
        cycle(1'b1, mk_tri(32'h200), 1'b0);
        cycle(1'b1, mk_tri(32'h300), 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, mk_tri(32'h400), 1'b1);
        chk("wfp_full", 32'(fifo_full), 1);
        chk("wfp_overflow", 32'(overflow), 0);
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1);

        // Fill and overflow.
        cycle(1'b1, mk_tri(32'h500), 1'b0);
        cycle(1'b1, mk_tri(32'h600), 1'b0);
        chk("fill_full", 32'(fifo_full), 1);
        cycle(1'b1, mk_tri(32'h700), 1'b0);
        chk("fill_overflow", 32'(overflow), 1);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);

        // Counter wrap over 256 back-to-back triangles.
        do_reset();
        for (int t = 0; t < 256; t++) begin
            cycle(1'b1, rand_word(), 1'b1);
            cycle(1'b0, '0, 1'b1);
            cycle(1'b0, '0, 1'b1);
        end
        cycle(1'b0, '0, 1'b1);
        chk("wrap_count", 32'(tri_count), 0);

        // Reset mid-stream with two entries queued and idx at 1.
        cycle(1'b1, mk_tri(32'h800), 1'b0);
        cycle(1'b1, mk_tri(32'h900), 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("pre_rst_idx", 32'(vtx_idx), 1);
        vtx_ready = 1'b0;
        #1;
        do_reset();
        cycle(1'b1, mk_tri(32'hA00), 1'b1);
        chk("post_rst_x", 32'(vtx_x), 32'h0A01);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cycle(logic'($urandom_range(0, 2) == 0), rand_word(),
                  logic'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
